arf132b192e1r1w0cbbehcaa4acw_wr_stage: RTL and testbench

//   Write-port staging for the 1R1W array. Accepts write requests over valid/ready, buffers up to 2,

---
 rtl/arf132b192e1r1w0cbbehcaa4acw_pkg.sv | 13 +
 rtl/arf132b192e1r1w0cbbehcaa4acw_wr_skid.sv | 47 ++++
 rtl/arf132b192e1r1w0cbbehcaa4acw_wr_stage.sv | 81 ++++++++
 tb/tb_arf132b192e1r1w0cbbehcaa4acw_wr_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/arf132b192e1r1w0cbbehcaa4acw_pkg.sv
// arf132b192e1r1w0cbbehcaa4acw_pkg: shared geometry, request record and occupancy states for the write stage
package arf132b192e1r1w0cbbehcaa4acw_pkg;
    localparam int DWIDTH = 132;
    localparam int DEPTH  = 192;
    localparam int AWIDTH = $clog2(DEPTH);

    typedef struct packed {
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] data;
    } wr_req_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;
endpackage

// File: rtl/arf132b192e1r1w0cbbehcaa4acw_wr_skid.sv
// arf132b192e1r1w0cbbehcaa4acw_wr_skid: 2-entry in-order write buffer; entry 0 is always the head
module arf132b192e1r1w0cbbehcaa4acw_wr_skid
    import arf132b192e1r1w0cbbehcaa4acw_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  wr_req_t din,
    output occ_t    occ,
    output occ_t    occ_nxt,
    output wr_req_t head,
    output wr_req_t tail,
    output logic    head_vld,
    output logic    tail_vld
);
    wr_req_t e0, e1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) occ <= EMPTY;
        else      occ <= occ_nxt;
    end

    always_comb begin
        occ_nxt = occ;
        case (occ)
            EMPTY:   occ_nxt = push ? ONE : EMPTY;
            ONE:     occ_nxt = (push && !pop) ? TWO : (!push && pop) ? EMPTY : ONE;
            default: occ_nxt = (pop && !push) ? ONE : TWO;
        endcase
    end

    // Data storage needs no reset: validity is carried entirely by occ.
    always_ff @(posedge clk) begin
        if (push && (occ == EMPTY || (occ == ONE && pop)))
            e0 <= din;
        else if (pop && occ == TWO)
            e0 <= e1;
        if (push && ((occ == ONE && !pop) || (occ == TWO && pop)))
            e1 <= din;
    end

    assign head     = e0;
    assign tail     = e1;
    assign head_vld = occ != EMPTY;
    assign tail_vld = occ == TWO;
endmodule

// File: rtl/arf132b192e1r1w0cbbehcaa4acw_wr_stage.sv
// arf132b192e1r1w0cbbehcaa4acw_wr_stage: write staging for the 1R1W array with range check, issue regs and RAW bypass
module arf132b192e1r1w0cbbehcaa4acw_wr_stage
    import arf132b192e1r1w0cbbehcaa4acw_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [AWIDTH-1:0] in_addr,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              arr_rdy,
    output logic              out_wen,
    output logic [AWIDTH-1:0] out_waddr,
    output logic [DWIDTH-1:0] out_wdata,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic              byp_hit,
    output logic [DWIDTH-1:0] byp_data,
    output logic              err_oor,
    output logic [7:0]        err_cnt
);
    occ_t    occ, occ_nxt;
    wr_req_t head, tail, req, issue;
    logic    head_vld, tail_vld;
    logic    accept, oor, push, nonempty, pop, sk_push, sk_pop;
    logic    hit_t, hit_h, hit_o;

    assign req      = '{addr: in_addr, data: in_data};
    assign accept   = in_vld && in_rdy;
    assign oor      = in_addr >= AWIDTH'(DEPTH);
    assign push     = accept && !oor;
    assign nonempty = occ != EMPTY;
    assign pop      = arr_rdy && (nonempty || push);
    // An empty buffer with a ready array sends the request straight to the issue regs.
    assign sk_push  = push && (nonempty || !arr_rdy);
    assign sk_pop   = arr_rdy && nonempty;
    assign issue    = nonempty ? head : req;

    arf132b192e1r1w0cbbehcaa4acw_wr_skid u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (sk_push),
        .pop      (sk_pop),
        .din      (req),
        .occ      (occ),
        .occ_nxt  (occ_nxt),
        .head     (head),
        .tail     (tail),
        .head_vld (head_vld),
        .tail_vld (tail_vld)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_rdy    <= 1'b0;
            out_wen   <= 1'b0;
            out_waddr <= '0;
            out_wdata <= '0;
            err_oor   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            in_rdy  <= occ_nxt != TWO;
            out_wen <= pop;
            if (pop) begin
                out_waddr <= issue.addr;
                out_wdata <= issue.data;
            end
            err_oor <= accept && oor;
            if (accept && oor && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end

    // Youngest pending write wins: buffer tail, then head, then the issue regs.
    always_comb begin
        hit_t    = tail_vld && tail.addr == rd_addr;
        hit_h    = head_vld && head.addr == rd_addr;
        hit_o    = out_wen && out_waddr == rd_addr;
        byp_hit  = hit_t || hit_h || hit_o;
        byp_data = hit_t ? tail.data : hit_h ? head.data : hit_o ? out_wdata : '0;
    end
endmodule

// File: tb/tb_arf132b192e1r1w0cbbehcaa4acw_wr_stage.sv
// tb_arf132b192e1r1w0cbbehcaa4acw_wr_stage: directed table vectors plus reset and saturation sequences
module tb_arf132b192e1r1w0cbbehcaa4acw_wr_stage;
    import arf132b192e1r1w0cbbehcaa4acw_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_vld = 1'b0;
    logic              in_rdy;
    logic [AWIDTH-1:0] in_addr = '0;
    logic [DWIDTH-1:0] in_data = '0;
    logic              arr_rdy = 1'b0;
    logic              out_wen;
    logic [AWIDTH-1:0] out_waddr;
    logic [DWIDTH-1:0] out_wdata;
    logic [AWIDTH-1:0] rd_addr = '0;
    logic              byp_hit;
    logic [DWIDTH-1:0] byp_data;
    logic              err_oor;
    logic [7:0]        err_cnt;

    int nvec = 0;
    int nerr = 0;

    arf132b192e1r1w0cbbehcaa4acw_wr_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .arr_rdy   (arr_rdy),
        .out_wen   (out_wen),
        .out_waddr (out_waddr),
        .out_wdata (out_wdata),
        .rd_addr   (rd_addr),
        .byp_hit   (byp_hit),
        .byp_data  (byp_data),
        .err_oor   (err_oor),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       vld;
        logic [7:0] addr;
        logic [7:0] data;
        logic       arr;
        logic [7:0] rd;
        logic       rdy;
        logic       wen;
        logic [7:0] waddr;
        logic [7:0] wdata;
        logic       hit;
        logic [7:0] bdata;
        logic       oor;
        logic [7:0] cnt;
    } vec_t;

    vec_t tv[17];

    task automatic chk(input string name, input logic [DWIDTH-1:0] act, input logic [DWIDTH-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic vld, input logic [7:0] addr, input logic [7:0] data,
                        input logic arr, input logic [7:0] rd);
        @(negedge clk);
        in_vld  = vld;
        in_addr = addr;
        in_data = {124'b0, data};
        arr_rdy = arr;
        rd_addr = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //       vld addr   data   arr rd     rdy wen waddr  wdata  hit bdata  oor cnt
        tv[0]  = '{1, 8'd5,  8'hA5, 1, 8'd5,  1, 1, 8'd5,  8'hA5, 1, 8'hA5, 0, 8'd0};
        tv[1]  = '{0, 8'd0,  8'h00, 1, 8'd5,  1, 0, 8'd0,  8'h00, 0, 8'h00, 0, 8'd0};
        tv[2]  = '{1, 8'd1,  8'h11, 0, 8'd1,  1, 0, 8'd0,  8'h00, 1, 8'h11, 0, 8'd0};
        tv[3]  = '{1, 8'd2,  8'h22, 0, 8'd1,  0, 0, 8'd0,  8'h00, 1, 8'h11, 0, 8'd0};
        tv[4]  = '{1, 8'd3,  8'h33, 0, 8'd2,  0, 0, 8'd0,  8'h00, 1, 8'h22, 0, 8'd0};
        tv[5]  = '{1, 8'd3,  8'h33, 1, 8'd3,  1, 1, 8'd1,  8'h11, 0, 8'h00, 0, 8'd0};
        tv[6]  = '{1, 8'd3,  8'h33, 1, 8'd3,  1, 1, 8'd2,  8'h22, 1, 8'h33, 0, 8'd0};
        tv[7]  = '{0, 8'd0,  8'h00, 1, 8'd3,  1, 1, 8'd3,  8'h33, 1, 8'h33, 0, 8'd0};
        tv[8]  = '{0, 8'd0,  8'h00, 1, 8'd3,  1, 0, 8'd0,  8'h00, 0, 8'h00, 0, 8'd0};
        tv[9]  = '{1, 8'd7,  8'h70, 0, 8'd7,  1, 0, 8'd0,  8'h00, 1, 8'h70, 0, 8'd0};
        tv[10] = '{1, 8'd7,  8'h71, 0, 8'd7,  0, 0, 8'd0,  8'h00, 1, 8'h71, 0, 8'd0};
        tv[11] = '{0, 8'd0,  8'h00, 0, 8'd8,  0, 0, 8'd0,  8'h00, 0, 8'h00, 0, 8'd0};
        tv[12] = '{0, 8'd0,  8'h00, 1, 8'd7,  1, 1, 8'd7,  8'h70, 1, 8'h71, 0, 8'd0};
        tv[13] = '{0, 8'd0,  8'h00, 1, 8'd7,  1, 1, 8'd7,  8'h71, 1, 8'h71, 0, 8'd0};
        tv[14] = '{0, 8'd0,  8'h00, 1, 8'd0,  1, 0, 8'd0,  8'h00, 0, 8'h00, 0, 8'd0};
        tv[15] = '{1, 8'd192,8'h99, 1, 8'd0,  1, 0, 8'd0,  8'h00, 0, 8'h00, 1, 8'd1};
        tv[16] = '{0, 8'd0,  8'h00, 1, 8'd0,  1, 0, 8'd0,  8'h00, 0, 8'h00, 0, 8'd1};

        // power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk("por_in_rdy", in_rdy, 0);
        chk("por_out_wen", out_wen, 0);
        chk("por_err_cnt", err_cnt, 0);
        chk("por_out_wdata", out_wdata, 0);
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, 0, 1, 0);
        chk("rel_in_rdy", in_rdy, 1);
        chk("rel_out_wen", out_wen, 0);

        foreach (tv[i]) begin
            step(tv[i].vld, tv[i].addr, tv[i].data, tv[i].arr, tv[i].rd);
            chk($sformatf("v%0d_in_rdy", i), in_rdy, tv[i].rdy);
            chk($sformatf("v%0d_out_wen", i), out_wen, tv[i].wen);
            if (tv[i].wen) begin
                chk($sformatf("v%0d_out_waddr", i), out_waddr, tv[i].waddr);
                chk($sformatf("v%0d_out_wdata", i), out_wdata, {124'b0, tv[i].wdata});
            end
            chk($sformatf("v%0d_byp_hit", i), byp_hit, tv[i].hit);
            chk($sformatf("v%0d_byp_data", i), byp_data, {124'b0, tv[i].bdata});
            chk($sformatf("v%0d_err_oor", i), err_oor, tv[i].oor);
            chk($sformatf("v%0d_err_cnt", i), err_cnt, tv[i].cnt);
        end

        // 300 back-to-back out-of-range writes: count saturates, nothing issues
        for (int i = 0; i < 300; i++) begin
            step(1, 8'(200 + i % 50), 8'h5A, 1, 0);
            if (i == 99) begin
                chk("sat_mid_cnt", err_cnt, 101);
                chk("sat_mid_oor", err_oor, 1);
                chk("sat_mid_wen", out_wen, 0);
            end
        end
        chk("sat_cnt", err_cnt, 255);
        chk("sat_in_rdy", in_rdy, 1);
        step(0, 0, 0, 1, 0);
        chk("sat_oor_clear", err_oor, 0);
        chk("sat_cnt_hold", err_cnt, 255);

        // reset mid-stream with two writes buffered
        step(1, 8'd10, 8'hB1, 0, 8'd10);
        step(1, 8'd11, 8'hB2, 0, 8'd10);
        chk("mid_full", in_rdy, 0);
        chk("mid_hit", byp_hit, 1);
        @(negedge clk);
        in_vld  = 1'b0;
        arr_rdy = 1'b1;
        rst     = 1'b0;
        #1;
        chk("mid_rst_wen", out_wen, 0);
        chk("mid_rst_rdy", in_rdy, 0);
        chk("mid_rst_cnt", err_cnt, 0);
        chk("mid_rst_hit", byp_hit, 0);
        @(posedge clk);
        #1;
        chk("mid_rst_wen2", out_wen, 0);
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, 0, 1, 8'd10);
        chk("post_rdy", in_rdy, 1);
        chk("post_wen", out_wen, 0);
        chk("post_hit10", byp_hit, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 8'd11);
            chk($sformatf("post_idle%0d_wen", i), out_wen, 0);
            chk($sformatf("post_idle%0d_hit", i), byp_hit, 0);
        end
        step(1, 8'd191, 8'hC3, 1, 8'd191);
        chk("post_edge_wen", out_wen, 1);
        chk("post_edge_addr", out_waddr, 191);
        chk("post_edge_data", out_wdata, {124'b0, 8'hC3});
        chk("post_edge_oor", err_oor, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
